// File: rtl/xsip_telemetry_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : xsip_telemetry_pkg
//  Purpose  : Shared types and constants for the telemetry scheduler:
//             FSM state encoding, telemetry source encoding, payload width.
//  Revision : 1.0  initial release
// ============================================================================
package xsip_telemetry_pkg;

    // Width of one telemetry payload word
    localparam int unsigned PAYLOAD_W = 256;

    // Source encoding carried on the *_src outputs
    localparam logic SRC_IC    = 1'b0;
    localparam logic SRC_BOARD = 1'b1;

    // Scheduler FSM encoding; visible on the state output
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT      = 2'd1,
        ST_SEND_PCIE  = 2'd2,
        ST_SEND_XRBUS = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/xsip_telemetry_scheduler_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : xsip_tick_gen
//  Purpose  : Free-running sample tick generator. Counts 0..PERIOD-1 while
//             enabled and asserts tick_o during the cycle in which the count
//             wraps back to 0. Disabling holds the count at 0.
//  Ports    : clk       - clock, rising edge
//             rst_n     - asynchronous active-low reset
//             enable_i  - count enable
//             tick_o    - one-cycle tick pulse
//  Revision : 1.0  initial release
// ============================================================================
module xsip_tick_gen #(
    parameter int unsigned PERIOD = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    output logic tick_o
);

    localparam logic [15:0] c_LAST = 16'(PERIOD - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        w_wrap;

    assign w_wrap = (cnt_q == c_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i || w_wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick is presented in the last count cycle so the FSM reacts on the
    // same edge at which the counter wraps to 0.
    assign tick_o = enable_i & w_wrap;

endmodule
`default_nettype wire

// File: rtl/xsip_telemetry_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : xsip_telemetry_scheduler
//  Purpose  : Periodically samples IC-level or board-level telemetry
//             (round-robin when both request) and forwards the sample as a
//             PCIe vendor message. If the PCIe sink does not accept within
//             TIMEOUT cycles the sample is rerouted to XR-BUS and a sticky
//             fallback flag routes all further samples to XR-BUS until
//             cleared. Ticks arriving while busy are counted, not queued.
//  Ports    : clk, rst_n                      - clock / async active-low reset
//             enable_i                        - tick generation enable
//             ic_valid_i/ic_data_i/ic_ready_o - IC requester (ready = grant)
//             board_valid_i/board_data_i/board_ready_o - board requester
//             pcie_valid_o/pcie_data_o/pcie_src_o/pcie_ready_i  - PCIe sink
//             xrbus_valid_o/xrbus_data_o/xrbus_src_o/xrbus_ready_i - XR-BUS
//             fallback_clr_i / fallback_active_o - sticky fallback flag
//             missed_ticks_o                  - saturating missed-tick count
//             state_o                         - current FSM encoding
//  Revision : 1.0  initial release
// ============================================================================
module xsip_telemetry_scheduler
    import xsip_telemetry_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic                 ic_valid_i,
    input  logic [PAYLOAD_W-1:0] ic_data_i,
    output logic                 ic_ready_o,
    input  logic                 board_valid_i,
    input  logic [PAYLOAD_W-1:0] board_data_i,
    output logic                 board_ready_o,
    output logic                 pcie_valid_o,
    output logic [PAYLOAD_W-1:0] pcie_data_o,
    output logic                 pcie_src_o,
    input  logic                 pcie_ready_i,
    output logic                 xrbus_valid_o,
    output logic [PAYLOAD_W-1:0] xrbus_data_o,
    output logic                 xrbus_src_o,
    input  logic                 xrbus_ready_i,
    input  logic                 fallback_clr_i,
    output logic                 fallback_active_o,
    output logic [15:0]          missed_ticks_o,
    output logic [1:0]           state_o
);

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    state_e               state_q,     state_d;
    logic [7:0]           wait_q,      wait_d;
    logic                 rr_q,        rr_d;        // source preferred on a tie
    logic [PAYLOAD_W-1:0] hold_data_q, hold_data_d;
    logic                 hold_src_q,  hold_src_d;
    logic                 fallback_q,  fallback_d;
    logic [15:0]          missed_q,    missed_d;

    logic w_tick;
    logic w_grant_ic;
    logic w_grant_board;
    logic w_set_fb;

    xsip_tick_gen #(
        .PERIOD   (SAMPLE_PERIOD)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (enable_i),
        .tick_o   (w_tick)
    );

    // A lone requester always wins; on a tie the round-robin pointer decides.
    assign w_grant_ic    = ic_valid_i    & (~board_valid_i | (rr_q == SRC_IC));
    assign w_grant_board = board_valid_i & (~ic_valid_i    | (rr_q == SRC_BOARD));

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        rr_d          = rr_q;
        hold_data_d   = hold_data_q;
        hold_src_d    = hold_src_q;
        w_set_fb      = 1'b0;
        ic_ready_o    = 1'b0;
        board_ready_o = 1'b0;
        pcie_valid_o  = 1'b0;
        xrbus_valid_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (w_tick) begin
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                wait_d = '0;
                if (w_grant_ic) begin
                    ic_ready_o  = 1'b1;
                    hold_data_d = ic_data_i;
                    hold_src_d  = SRC_IC;
                    rr_d        = SRC_BOARD;
                end else if (w_grant_board) begin
                    board_ready_o = 1'b1;
                    hold_data_d   = board_data_i;
                    hold_src_d    = SRC_BOARD;
                    rr_d          = SRC_IC;
                end

                if (w_grant_ic || w_grant_board) begin
                    state_d = fallback_q ? ST_SEND_XRBUS : ST_SEND_PCIE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SEND_PCIE: begin
                pcie_valid_o = 1'b1;
                if (pcie_ready_i) begin
                    state_d = ST_IDLE;
                end else if (wait_q == c_TO_LAST) begin
                    // TIMEOUT-th unaccepted cycle: reroute the held sample
                    state_d  = ST_SEND_XRBUS;
                    wait_d   = '0;
                    w_set_fb = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            ST_SEND_XRBUS: begin
                xrbus_valid_o = 1'b1;
                if (xrbus_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Set dominates clear so a timeout is never lost
    always_comb begin
        fallback_d = fallback_q;
        if (w_set_fb) begin
            fallback_d = 1'b1;
        end else if (fallback_clr_i) begin
            fallback_d = 1'b0;
        end
    end

    always_comb begin
        missed_d = missed_q;
        if (w_tick && (state_q != ST_IDLE) && (missed_q != 16'hFFFF)) begin
            missed_d = missed_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            rr_q        <= SRC_IC;
            hold_data_q <= '0;
            hold_src_q  <= SRC_IC;
            fallback_q  <= 1'b0;
            missed_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            rr_q        <= rr_d;
            hold_data_q <= hold_data_d;
            hold_src_q  <= hold_src_d;
            fallback_q  <= fallback_d;
            missed_q    <= missed_d;
        end
    end

    // Both sinks see the same holding register; only one valid is ever high
    assign pcie_data_o       = hold_data_q;
    assign pcie_src_o        = hold_src_q;
    assign xrbus_data_o      = hold_data_q;
    assign xrbus_src_o       = hold_src_q;
    assign fallback_active_o = fallback_q;
    assign missed_ticks_o    = missed_q;
    assign state_o           = state_q;

endmodule
`default_nettype wire

// File: doc/xsip_telemetry_scheduler.md
XSIP_TELEMETRY_SCHEDULER -- requirements
Module: xsip_telemetry_scheduler

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 1000, cycles between sample ticks (legal range 2..65535).
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum cycles waiting for pcie_ready before fallback (legal range 1..255).
REQ-003 clk  input  1  clock, all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  sample ticks generated only while high.
REQ-006 ic_valid / ic_data  input  1 / 256  IC-level telemetry request and payload.
REQ-007 ic_ready  output  1  one-cycle grant pulse; ic_data captured that cycle.
REQ-008 board_valid / board_data  input  1 / 256  board-level request and payload.
REQ-009 board_ready  output  1  one-cycle grant pulse for board.
REQ-010 pcie_valid / pcie_data / pcie_src  output  1 / 256 / 1  PCIe vendor-message sample; src 0=IC, 1=board.
REQ-011 pcie_ready  input  1  PCIe sink accept.
REQ-012 xrbus_valid / xrbus_data / xrbus_src  output  1 / 256 / 1  XR-BUS fallback sample.
REQ-013 xrbus_ready  input  1  XR-BUS sink accept.
REQ-014 fallback_clr  input  1  clears fallback_active.
REQ-015 fallback_active  output  1  sticky; set on any PCIe timeout.
REQ-016 missed_ticks  output  16  ticks arriving while not IDLE, saturating.
REQ-017 state  output  2  current FSM encoding.

Function
REQ-018 Tick counter SHALL count 0..SAMPLE_PERIOD-1 while enable=1, pulse tick when wrapping to 0; enable=0 holds counter at 0.
REQ-019 FSM states SHALL be IDLE=0, GRANT=1, SEND_PCIE=2, SEND_XRBUS=3.
REQ-020 IDLE: tick -> GRANT; otherwise stay.
REQ-021 GRANT (one cycle): if neither valid -> IDLE, nothing sent, no count; if one valid -> grant it; if both valid -> round-robin, granting the source not granted last (IC first after reset).
REQ-022 On grant SHALL pulse the matching *_ready, capture payload and src into holding register, update round-robin pointer.
REQ-023 Next state after grant: SEND_XRBUS if fallback_active=1, else SEND_PCIE.
REQ-024 SEND_PCIE: pcie_valid=1 with held data; pcie_ready=1 -> IDLE next cycle; wait counter SHALL increment per non-accept cycle, and on reaching TIMEOUT SHALL drop pcie_valid, set fallback_active, enter SEND_XRBUS with same sample.
REQ-025 SEND_XRBUS: xrbus_valid=1 with held data until xrbus_ready=1, then IDLE; no timeout.
REQ-026 pcie_valid and xrbus_valid SHALL never be high simultaneously; held data SHALL not change while valid high.
REQ-027 Tick while state != IDLE SHALL increment missed_ticks (saturate at 65535) and SHALL not be queued.
REQ-028 fallback_clr SHALL clear fallback_active; simultaneous timeout and fallback_clr -> set wins.
REQ-029 enable falling mid-transfer SHALL not abort current transfer.
REQ-030 Latency tick -> pcie_valid SHALL be 2 cycles (GRANT, then SEND_PCIE).

Reset
REQ-031 Asserting rst_n low SHALL immediately clear all outputs to 0, state to IDLE, tick and wait counters to 0, round-robin pointer to IC, holding register to 0, abandoning any transfer.
REQ-032 Reset release SHALL begin counting ticks from 0 on the first clk edge.

Structure
REQ-033 Shared package xsip_telemetry_pkg SHALL hold the FSM state enum, source encoding (SRC_IC, SRC_BOARD), payload width constant 256.
REQ-034 Tick generation SHALL be sub-module xsip_tick_gen (enable, period, tick); remainder flat.

Verification
REQ-035 SAMPLE_PERIOD=10, ic_valid only, pcie_ready=1 -> ic_ready pulse at cycle 10, pcie_valid cycle 11, pcie_src=0, IDLE cycle 12.
REQ-036 Both valid held high, four ticks -> grants IC, board, IC, board; pcie_src 0,1,0,1.
REQ-037 TIMEOUT=4, pcie_ready=0 -> pcie_valid high 4 cycles, then xrbus_valid with same data, fallback_active=1; next sample goes straight to XR-BUS until fallback_clr.
REQ-038 SAMPLE_PERIOD=2, xrbus_ready held 0 for 10 cycles in SEND_XRBUS -> missed_ticks=5, no extra grants.
REQ-039 No requester valid at tick -> no ready pulse, no valid, missed_ticks unchanged.
REQ-040 rst_n asserted during SEND_PCIE -> pcie_valid low same cycle, state IDLE, fallback_active 0, next grant goes to IC.
